gate_resp_checker: RTL and testbench

GATE_RESP_CHECKER -- requirements
Module: gate_resp_checker

---
 rtl/gate_resp_checker_pkg.sv | 43 ++++
 rtl/gate_resp_checker_if.sv | 28 ++
 rtl/gate_ref_model.sv | 13 +
 rtl/gate_resp_checker.sv | 148 ++++++++++++++
 tb/tb_gate_resp_checker.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_resp_checker_pkg.sv
// Shared types for the gate response checker: the op encoding, the FSM states,
// and the expected-response function.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] COV_FULL = 4'hF;
    localparam logic [7:0] ERR_MAX  = 8'hFF;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

    // Codes 6 and 7 never reach a compare; they return 0.
    function automatic logic gate_expect(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_resp_checker_if.sv
// Control, stimulus and result signals between a test driver (master) and the
// gate response checker (slave).
interface gate_resp_checker_if;
    logic       start;
    logic [2:0] op;
    logic       a;
    logic       b;
    logic       o;
    logic       sample;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeout;
    logic [7:0] err_cnt;
    logic [3:0] cov;
    logic [1:0] first_err_vec;
    logic       first_err_vld;

    modport master (
        output start, op, a, b, o, sample,
        input  busy, done, pass, timeout, err_cnt, cov, first_err_vec, first_err_vld
    );

    modport slave (
        input  start, op, a, b, o, sample,
        output busy, done, pass, timeout, err_cnt, cov, first_err_vec, first_err_vld
    );
endinterface

// File: rtl/gate_ref_model.sv
// Combinational golden gate: the response a correct DUT must give for op/a/b.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic       i_a,
    input  logic       i_b,
    output logic       o_exp
);

    assign o_exp = gate_expect(i_op, i_a, i_b);

endmodule

// File: rtl/gate_resp_checker.sv
// Runs a check of one 2-input gate: waits for sampled vectors, compares the DUT
// response after a settle window, and tracks errors, coverage and timeout.
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    gate_resp_checker_if.slave  bus
);

    localparam int              TMO_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_e           r_state;
    logic [2:0]       r_op;
    logic [1:0]       r_ab;
    logic [3:0]       r_settle;
    logic [TMO_W-1:0] r_tmo;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_timeout;
    logic [7:0]       r_err_cnt;
    logic [3:0]       r_cov;
    logic [1:0]       r_fev;
    logic             r_fevld;

    logic             w_exp;
    logic             w_mismatch;
    logic [3:0]       w_cov_nxt;
    logic [7:0]       w_err_nxt;

    gate_ref_model u_ref (
        .i_op  (r_op),
        .i_a   (r_ab[1]),
        .i_b   (r_ab[0]),
        .o_exp (w_exp)
    );

    // Result of the compare that happens in the last SETTLE cycle.
    always_comb begin
        w_mismatch = (bus.o != w_exp);
        w_cov_nxt  = r_cov | (4'b0001 << r_ab);
        if (w_mismatch && (r_err_cnt != ERR_MAX)) begin
            w_err_nxt = r_err_cnt + 8'd1;
        end else begin
            w_err_nxt = r_err_cnt;
        end
    end

    // Check-run FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= 3'd0;
            r_ab      <= 2'd0;
            r_settle  <= 4'd0;
            r_tmo     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_err_cnt <= 8'd0;
            r_cov     <= 4'd0;
            r_fev     <= 2'd0;
            r_fevld   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state   <= ST_RUN;
                        r_op      <= bus.op;
                        r_tmo     <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_err_cnt <= 8'd0;
                        r_cov     <= 4'd0;
                        r_fev     <= 2'd0;
                        r_fevld   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!op_legal(r_op)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b0;
                    end else if (bus.sample) begin
                        // A sample on the terminal-count cycle still wins.
                        r_state  <= ST_SETTLE;
                        r_ab     <= {bus.a, bus.b};
                        r_settle <= SETTLE_LOAD;
                    end else if (r_tmo == TMO_LAST) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == 4'd0) begin
                        r_err_cnt <= w_err_nxt;
                        r_cov     <= w_cov_nxt;
                        if (w_mismatch && !r_fevld) begin
                            r_fev   <= r_ab;
                            r_fevld <= 1'b1;
                        end
                        if (w_cov_nxt == COV_FULL) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == 8'd0) && !r_timeout;
                        end else begin
                            r_state <= ST_RUN;
                            r_tmo   <= '0;
                        end
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.pass          = r_pass;
    assign bus.timeout       = r_timeout;
    assign bus.err_cnt       = r_err_cnt;
    assign bus.cov           = r_cov;
    assign bus.first_err_vec = r_fev;
    assign bus.first_err_vld = r_fevld;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Scoreboard bench: each run pushes its expected result, and per-DUT monitors
// compare the outputs whenever done rises.
module tb_gate_resp_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a;
    logic       start_b;
    logic [2:0] op;
    logic       a;
    logic       b;
    logic       o;
    logic       sample;

    always #5 clk = ~clk;

    gate_resp_checker_if ifa ();
    gate_resp_checker_if ifb ();

    assign ifa.start = start_a;
    assign ifa.op = op;
    assign ifa.a = a;
    assign ifa.b = b;
    assign ifa.o = o;
    assign ifa.sample = sample;
    assign ifb.start = start_b;
    assign ifb.op = op;
    assign ifb.a = a;
    assign ifb.b = b;
    assign ifb.o = o;
    assign ifb.sample = sample;

    gate_resp_checker #(.SETTLE_CYC(2), .TIMEOUT_CYC(64)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    gate_resp_checker #(.SETTLE_CYC(3), .TIMEOUT_CYC(64)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    typedef struct packed {
        logic       pass;
        logic       tmo;
        logic [7:0] err;
        logic [3:0] cov;
        logic [1:0] fev;
        logic       fevld;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic done_a_q = 1'b0;
    logic done_b_q = 1'b0;

    // Truth tables indexed by {a,b}: AND, OR, NAND, NOR, XOR, XNOR.
    logic [3:0] tt [0:5] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_res(input string tag, input exp_t e, input logic pass, input logic tmo,
                             input logic [7:0] err, input logic [3:0] cov, input logic [1:0] fev,
                             input logic fevld);
        chk({tag, "_pass"}, pass, e.pass);
        chk({tag, "_timeout"}, tmo, e.tmo);
        chk({tag, "_err_cnt"}, err, e.err);
        chk({tag, "_cov"}, cov, e.cov);
        chk({tag, "_first_err_vld"}, fevld, e.fevld);
        if (e.fevld) chk({tag, "_first_err_vec"}, fev, e.fev);
    endtask

    // Monitor for dut_a.
    always @(negedge clk) begin
        exp_t e;
        if (ifa.done && !done_a_q) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_done", 1, 0);
            end else begin
                e = qa.pop_front();
                check_res("a", e, ifa.pass, ifa.timeout, ifa.err_cnt, ifa.cov,
                          ifa.first_err_vec, ifa.first_err_vld);
            end
        end
        done_a_q = ifa.done;
    end

    // Monitor for dut_b.
    always @(negedge clk) begin
        exp_t e;
        if (ifb.done && !done_b_q) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_done", 1, 0);
            end else begin
                e = qb.pop_front();
                check_res("b", e, ifb.pass, ifb.timeout, ifb.err_cnt, ifb.cov,
                          ifb.first_err_vec, ifb.first_err_vld);
            end
        end
        done_b_q = ifb.done;
    end

    task automatic push_exp(input int sel, input logic pass, input logic tmo, input logic [7:0] err,
                            input logic [3:0] cov, input logic [1:0] fev, input logic fevld);
        exp_t e;
        e = '{pass: pass, tmo: tmo, err: err, cov: cov, fev: fev, fevld: fevld};
        if (sel == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic do_start(input int sel, input logic [2:0] opv);
        @(negedge clk);
        op = opv;
        if (sel == 0) start_a = 1'b1;
        else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // o holds o1 through the sample edge and the next one, then switches to o2.
    task automatic do_sample(input logic av, input logic bv, input logic o1, input logic o2);
        @(negedge clk);
        a = av;
        b = bv;
        o = o1;
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        @(negedge clk);
        o = o2;
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_done(input int sel, input int max, output int cyc);
        logic d;
        cyc = 0;
        d = (sel == 0) ? ifa.done : ifb.done;
        while (!d && cyc < max) begin
            @(negedge clk);
            cyc++;
            d = (sel == 0) ? ifa.done : ifb.done;
        end
        chk("wait_done", d, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, ifa.busy, 0);
        chk({tag, "_done"}, ifa.done, 0);
        chk({tag, "_pass"}, ifa.pass, 0);
        chk({tag, "_timeout"}, ifa.timeout, 0);
        chk({tag, "_err_cnt"}, ifa.err_cnt, 0);
        chk({tag, "_cov"}, ifa.cov, 0);
        chk({tag, "_fev"}, ifa.first_err_vec, 0);
        chk({tag, "_fevld"}, ifa.first_err_vld, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        logic [3:0] t;
        logic [1:0] ab;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        op = 3'd0;
        a = 1'b0;
        b = 1'b0;
        o = 1'b0;
        sample = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        chk("reset_b_busy", ifb.busy, 0);
        chk("reset_b_done", ifb.done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // NOR, correct DUT, with an ignored start pulse mid-run.
        push_exp(0, 1'b1, 1'b0, 8'd0, 4'hF, 2'd0, 1'b0);
        do_start(0, 3'd3);
        chk("busy_in_run", ifa.busy, 1);
        do_sample(1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        do_sample(1'b0, 1'b1, 1'b0, 1'b0);
        do_sample(1'b1, 1'b0, 1'b0, 1'b0);
        do_sample(1'b1, 1'b1, 1'b0, 1'b0);
        wait_done(0, 100, cyc);
        chk("busy_in_done", ifa.busy, 0);

        // Every legal op with a correct DUT, vectors in descending order.
        for (int opi = 0; opi < 6; opi++) begin
            t = tt[opi];
            push_exp(0, 1'b1, 1'b0, 8'd0, 4'hF, 2'd0, 1'b0);
            do_start(0, 3'(opi));
            for (int v = 3; v >= 0; v--) begin
                ab = 2'(v);
                do_sample(ab[1], ab[0], t[ab], t[ab]);
            end
            wait_done(0, 100, cyc);
        end

        // NOR with the DUT stuck at 1.
        push_exp(0, 1'b0, 1'b0, 8'd3, 4'hF, 2'b01, 1'b1);
        do_start(0, 3'd3);
        for (int v = 0; v < 4; v++) begin
            ab = 2'(v);
            do_sample(ab[1], ab[0], 1'b1, 1'b1);
        end
        wait_done(0, 100, cyc);

        // AND with no samples: timeout after exactly 64 RUN cycles.
        push_exp(0, 1'b0, 1'b1, 8'd0, 4'h0, 2'd0, 1'b0);
        do_start(0, 3'd0);
        wait_done(0, 100, cyc);
        chk("timeout_latency", cyc, 64);

        // Illegal op: done two cycles after start.
        push_exp(0, 1'b0, 1'b0, 8'd0, 4'h0, 2'd0, 1'b0);
        do_start(0, 3'd7);
        chk("op7_done_1cyc", ifa.done, 0);
        @(negedge clk);
        chk("op7_done_2cyc", ifa.done, 1);
        chk("op7_busy", ifa.busy, 0);

        // AND: 00 checked twice with a wrong response, then the rest correct.
        push_exp(0, 1'b0, 1'b0, 8'd2, 4'hF, 2'b00, 1'b1);
        do_start(0, 3'd0);
        do_sample(1'b0, 1'b0, 1'b1, 1'b1);
        do_sample(1'b0, 1'b0, 1'b1, 1'b1);
        chk("recheck_cov", ifa.cov, 1);
        do_sample(1'b0, 1'b1, 1'b0, 1'b0);
        do_sample(1'b1, 1'b0, 1'b0, 1'b0);
        do_sample(1'b1, 1'b1, 1'b1, 1'b1);
        wait_done(0, 100, cyc);

        // Reset during SETTLE aborts the run.
        do_start(0, 3'd3);
        @(negedge clk);
        a = 1'b0;
        b = 1'b1;
        o = 1'b1;
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        chk("settle_busy", ifa.busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rst_settle");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_settle_stays_idle", ifa.busy, 0);

        // SETTLE_CYC=3 with a late-correct XOR DUT.
        t = tt[4];
        push_exp(1, 1'b1, 1'b0, 8'd0, 4'hF, 2'd0, 1'b0);
        do_start(1, 3'd4);
        for (int v = 0; v < 4; v++) begin
            ab = 2'(v);
            do_sample(ab[1], ab[0], ~t[ab], t[ab]);
        end
        wait_done(1, 100, cyc);

        repeat (3) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
